// File: rtl/fir_pkg.sv
// Shared definitions for the fir_filter feeder blocks: tap count,
// default sample width and the window FSM state encoding.
package fir_pkg;

    localparam int NUM_TAPS          = 8;
    localparam int DEFAULT_BIT_WIDTH = 16;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient storage: a shadow bank written at any time and
// an active bank that only changes on a commit, so the filter never sees a mix.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int bit_width = DEFAULT_BIT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  we,
    input  logic [2:0]                            addr,
    input  logic [bit_width-1:0]                  data,
    input  logic                                  commit,
    input  logic                                  direct,
    input  logic                                  boundary,
    output logic [NUM_TAPS-1:0][bit_width-1:0]    active,
    output logic                                  pending
);

    logic [NUM_TAPS-1:0][bit_width-1:0] shadow;
    logic [NUM_TAPS-1:0][bit_width-1:0] shadow_next;
    logic                               do_copy;

    // The copy always sees this cycle's write, so write-then-copy falls out naturally.
    always_comb begin
        shadow_next = shadow;
        if (we) begin
            shadow_next[addr] = data;
        end
    end

    assign do_copy = (commit & direct) | (boundary & (commit | pending));

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            shadow <= shadow_next;
            if (do_copy) begin
                active <= shadow_next;
            end
            pending <= do_copy ? 1'b0 : (pending | commit);
        end
    end

endmodule

// File: rtl/fir_tap_window.sv
// Sample delay line and fill/run/flush control feeding an 8-tap fir_filter,
// with window-valid and output-valid strobes aligned to the filter's register.
module fir_tap_window
    import fir_pkg::*;
#(
    parameter int bit_width = DEFAULT_BIT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [bit_width-1:0] s_data,
    input  logic                        coef_we,
    input  logic [2:0]                  coef_addr,
    input  logic signed [bit_width-1:0] coef_data,
    input  logic                        coef_commit,
    input  logic                        flush,
    output logic signed [bit_width-1:0] x0,
    output logic signed [bit_width-1:0] x1,
    output logic signed [bit_width-1:0] x2,
    output logic signed [bit_width-1:0] x3,
    output logic signed [bit_width-1:0] x4,
    output logic signed [bit_width-1:0] x5,
    output logic signed [bit_width-1:0] x6,
    output logic signed [bit_width-1:0] x7,
    output logic signed [bit_width-1:0] coeff0,
    output logic signed [bit_width-1:0] coeff1,
    output logic signed [bit_width-1:0] coeff2,
    output logic signed [bit_width-1:0] coeff3,
    output logic signed [bit_width-1:0] coeff4,
    output logic signed [bit_width-1:0] coeff5,
    output logic signed [bit_width-1:0] coeff6,
    output logic signed [bit_width-1:0] coeff7,
    output logic                        win_valid,
    output logic                        y_valid,
    output logic [3:0]                  fill_count,
    output logic                        commit_pending
);

    localparam logic [3:0] FULL = 4'(NUM_TAPS);

    state_t                             state;
    logic [NUM_TAPS-1:0][bit_width-1:0] win;
    logic [NUM_TAPS-1:0][bit_width-1:0] active;
    logic                               accept;

    assign s_ready = (state != FLUSH);
    assign accept  = s_valid & s_ready & ~flush;

    assign x0 = win[0];
    assign x1 = win[1];
    assign x2 = win[2];
    assign x3 = win[3];
    assign x4 = win[4];
    assign x5 = win[5];
    assign x6 = win[6];
    assign x7 = win[7];

    assign coeff0 = active[0];
    assign coeff1 = active[1];
    assign coeff2 = active[2];
    assign coeff3 = active[3];
    assign coeff4 = active[4];
    assign coeff5 = active[5];
    assign coeff6 = active[6];
    assign coeff7 = active[7];

    // Pending commits land on the accept edge so the new bank lines up with the shifted window.
    fir_coef_bank #(
        .bit_width(bit_width)
    ) u_coef_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (coef_we),
        .addr     (coef_addr),
        .data     (coef_data),
        .commit   (coef_commit),
        .direct   (state != RUN),
        .boundary (accept),
        .active   (active),
        .pending  (commit_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            win        <= '0;
            fill_count <= '0;
            win_valid  <= 1'b0;
            y_valid    <= 1'b0;
        end else begin
            case (state)
                FLUSH: begin
                    win        <= '0;
                    fill_count <= '0;
                    win_valid  <= 1'b0;
                    y_valid    <= 1'b0;
                    state      <= flush ? FLUSH : FILL;
                end
                default: begin
                    if (flush) begin
                        state     <= FLUSH;
                        win_valid <= 1'b0;
                        y_valid   <= 1'b0;
                    end else begin
                        y_valid   <= win_valid;
                        win_valid <= accept && ((state == RUN) || (fill_count == FULL - 4'd1));
                        if (accept) begin
                            win        <= {win[NUM_TAPS-2:0], s_data};
                            fill_count <= (fill_count == FULL) ? FULL : fill_count + 4'd1;
                            if ((state == FILL) && (fill_count == FULL - 4'd1)) begin
                                state <= RUN;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_window.sv
// Directed self-checking bench for fir_tap_window: fill, streaming, coefficient
// commit timing, flush and mid-stream reset, with hand-computed expectations.
module tb_fir_tap_window;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [15:0] coef_data;
    logic        coef_commit;
    logic        flush;
    logic [15:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic [15:0] coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7;
    logic        win_valid;
    logic        y_valid;
    logic [3:0]  fill_count;
    logic        commit_pending;

    int checks;
    int failures;

    fir_tap_window #(
        .bit_width(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .coef_we        (coef_we),
        .coef_addr      (coef_addr),
        .coef_data      (coef_data),
        .coef_commit    (coef_commit),
        .flush          (flush),
        .x0             (x0),
        .x1             (x1),
        .x2             (x2),
        .x3             (x3),
        .x4             (x4),
        .x5             (x5),
        .x6             (x6),
        .x7             (x7),
        .coeff0         (coeff0),
        .coeff1         (coeff1),
        .coeff2         (coeff2),
        .coeff3         (coeff3),
        .coeff4         (coeff4),
        .coeff5         (coeff5),
        .coeff6         (coeff6),
        .coeff7         (coeff7),
        .win_valid      (win_valid),
        .y_valid        (y_valid),
        .fill_count     (fill_count),
        .commit_pending (commit_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs, then lets the edge happen and settles 1 time unit after it.
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic we,
                                 input logic [2:0] a, input logic [15:0] cd,
                                 input logic cm, input logic fl);
        s_valid     = v;
        s_data      = d;
        coef_we     = we;
        coef_addr   = a;
        coef_data   = cd;
        coef_commit = cm;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("rst_fill", 32'(fill_count), 32'd0);
        checkOutput("rst_wv", 32'(win_valid), 32'd0);
        checkOutput("rst_yv", 32'(y_valid), 32'd0);
        checkOutput("rst_ready", 32'(s_ready), 32'd1);
        checkOutput("rst_x0", 32'(x0), 32'd0);
        checkOutput("rst_coeff0", 32'(coeff0), 32'd0);
        checkOutput("rst_pending", 32'(commit_pending), 32'd0);
        rst = 1'b0;

        $display("[TB] fill with samples 1..8");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
            checkOutput("fill_count", 32'(fill_count), 32'(i));
            checkOutput("fill_wv", 32'(win_valid), (i == 8) ? 32'd1 : 32'd0);
            checkOutput("fill_yv", 32'(y_valid), 32'd0);
        end
        checkOutput("full_x0", 32'(x0), 32'd8);
        checkOutput("full_x3", 32'(x3), 32'd5);
        checkOutput("full_x7", 32'(x7), 32'd1);

        $display("[TB] streaming 9,10 then gaps");
        applyStimulus(1'b1, 16'd9, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("s9_wv", 32'(win_valid), 32'd1);
        checkOutput("s9_yv", 32'(y_valid), 32'd1);
        checkOutput("s9_x0", 32'(x0), 32'd9);
        applyStimulus(1'b1, 16'd10, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("s10_wv", 32'(win_valid), 32'd1);
        checkOutput("s10_x0", 32'(x0), 32'd10);
        checkOutput("s10_x7", 32'(x7), 32'd3);
        checkOutput("s10_fill", 32'(fill_count), 32'd8);
        applyStimulus(1'b0, 16'd99, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("gap_wv", 32'(win_valid), 32'd0);
        checkOutput("gap_yv", 32'(y_valid), 32'd1);
        checkOutput("gap_x0", 32'(x0), 32'd10);
        applyStimulus(1'b0, 16'd99, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("gap2_yv", 32'(y_valid), 32'd0);
        checkOutput("gap2_x7", 32'(x7), 32'd3);

        $display("[TB] deferred commit in RUN");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b1, 3'(i), 16'h0010 + 16'(i), 1'b0, 1'b0);
        end
        checkOutput("shadow_only_c0", 32'(coeff0), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("pend_set", 32'(commit_pending), 32'd1);
        checkOutput("pend_c0", 32'(coeff0), 32'd0);
        checkOutput("pend_c7", 32'(coeff7), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 3'd7, 16'h0027, 1'b1, 1'b0);
        checkOutput("pend_again", 32'(commit_pending), 32'd1);
        checkOutput("pend_again_c7", 32'(coeff7), 32'd0);
        applyStimulus(1'b1, 16'd11, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("apply_c0", 32'(coeff0), 32'h10);
        checkOutput("apply_c1", 32'(coeff1), 32'h11);
        checkOutput("apply_c6", 32'(coeff6), 32'h16);
        checkOutput("apply_c7", 32'(coeff7), 32'h27);
        checkOutput("apply_pend", 32'(commit_pending), 32'd0);
        checkOutput("apply_x0", 32'(x0), 32'd11);
        checkOutput("apply_x1", 32'(x1), 32'd10);
        checkOutput("apply_wv", 32'(win_valid), 32'd1);

        $display("[TB] flush in RUN with a sample present");
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
        checkOutput("fl_ready", 32'(s_ready), 32'd0);
        checkOutput("fl_x0_dropped", 32'(x0), 32'd11);
        checkOutput("fl_wv", 32'(win_valid), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("fl_done_ready", 32'(s_ready), 32'd1);
        checkOutput("fl_done_x0", 32'(x0), 32'd0);
        checkOutput("fl_done_x7", 32'(x7), 32'd0);
        checkOutput("fl_done_fill", 32'(fill_count), 32'd0);
        checkOutput("fl_done_yv", 32'(y_valid), 32'd0);
        checkOutput("fl_keep_c0", 32'(coeff0), 32'h10);
        checkOutput("fl_keep_c7", 32'(coeff7), 32'h27);

        $display("[TB] immediate commit in FILL");
        applyStimulus(1'b0, 16'h0, 1'b1, 3'd3, 16'h7FFF, 1'b1, 1'b0);
        checkOutput("fill_commit_c3", 32'(coeff3), 32'h7FFF);
        checkOutput("fill_commit_c0", 32'(coeff0), 32'h10);
        checkOutput("fill_commit_pend", 32'(commit_pending), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 3'd4, 16'h8000, 1'b1, 1'b0);
        checkOutput("neg_c4", 32'(coeff4), 32'h8000);
        checkOutput("neg_c3", 32'(coeff3), 32'h7FFF);
        applyStimulus(1'b1, 16'h8000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("neg_x0", 32'(x0), 32'h8000);
        checkOutput("neg_fill", 32'(fill_count), 32'd1);

        $display("[TB] reset mid-stream with a pending commit");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        end
        checkOutput("refill_wv", 32'(win_valid), 32'd1);
        checkOutput("refill_x7", 32'(x7), 32'h8000);
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("pre_rst_pend", 32'(commit_pending), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("mid_rst_pend", 32'(commit_pending), 32'd0);
        checkOutput("mid_rst_c3", 32'(coeff3), 32'd0);
        checkOutput("mid_rst_c4", 32'(coeff4), 32'd0);
        checkOutput("mid_rst_x0", 32'(x0), 32'd0);
        checkOutput("mid_rst_fill", 32'(fill_count), 32'd0);
        checkOutput("mid_rst_wv", 32'(win_valid), 32'd0);
        checkOutput("mid_rst_yv", 32'(y_valid), 32'd0);
        rst = 1'b0;
        #2;
        checkOutput("rst_low_fill", 32'(fill_count), 32'd0);
        checkOutput("rst_low_ready", 32'(s_ready), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("shadow_cleared_c0", 32'(coeff0), 32'd0);
        checkOutput("shadow_cleared_c3", 32'(coeff3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
